// File: rtl/gb_oam_dma_arbiter.sv
// gb_oam_dma_arbiter: owns the memory bus, passes CPU traffic through and runs OAM DMA from FF46.
// Define GB_DMA_BUS_CONFLICT_EN to return the in-flight DMA byte on blocked CPU reads instead of FF.
module gb_oam_dma_arbiter #(
  parameter int LEN = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_we_i,
  output logic [7:0]  cpu_data_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_we_o,
  input  logic [7:0]  bus_data_i,
  output logic        dma_active_o,
  output logic        dma_done_o
);
  typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_t;
  localparam logic [7:0] LAST = 8'(LEN - 1);
  localparam logic [2:0] DLY = 3'(START_DELAY);
  localparam state_t START = (START_DELAY == 0) ? READ : DELAY;
  state_t state_q, state_d;
  logic [7:0] idx_q, idx_d, ff46_q, ff46_d, latch_q, latch_d, src_hi, cflt;
  logic [2:0] cnt_q, cnt_d;
  logic done_q, done_d, is_ff46, cpu_pri, ff46_wr, busy, final_wr;
  always_comb begin
    is_ff46 = cpu_addr_i == 16'hFF46;
    cpu_pri = is_ff46 || (cpu_addr_i >= 16'hFF80 && cpu_addr_i != 16'hFFFF);
    ff46_wr = is_ff46 && cpu_we_i;
    busy = state_q == READ || state_q == WRITE;
    final_wr = state_q == WRITE && idx_q == LAST && ff46_wr;
    src_hi = ff46_q > 8'hDF ? ff46_q - 8'h20 : ff46_q;
`ifdef GB_DMA_BUS_CONFLICT_EN
    cflt = state_q == READ ? bus_data_i : latch_q;
`else
    cflt = 8'hFF;
`endif
  end
  always_comb begin
    ff46_d = ff46_wr ? cpu_data_i : ff46_q;
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    latch_d = latch_q;
    done_d = 1'b0;
    bus_addr_o = cpu_addr_i;
    bus_data_o = cpu_data_i;
    bus_we_o = cpu_we_i;
    cpu_data_o = is_ff46 ? ff46_q : bus_data_i;
    // an FF46 write landing on the final byte lets that byte reach OAM; only the register sees the CPU write
    if (busy && (!cpu_pri || final_wr)) begin
      bus_addr_o = state_q == READ ? {src_hi, idx_q} : 16'hFE00 + {8'h00, idx_q};
      bus_data_o = latch_q;
      bus_we_o = state_q == WRITE;
      cpu_data_o = cpu_pri ? cpu_data_o : cflt;
    end
    if (ff46_wr) begin
      state_d = START;
      cnt_d = DLY;
      idx_d = 8'h00;
    end else if (state_q == DELAY) begin
      cnt_d = cnt_q - 3'd1;
      state_d = cnt_q == 3'd1 ? READ : DELAY;
    end else if (busy && !cpu_pri) begin
      if (state_q == READ) begin
        latch_d = bus_data_i;
        state_d = WRITE;
      end else if (idx_q == LAST) begin
        state_d = IDLE;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + 8'd1;
        state_d = READ;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= 8'h00;
      cnt_q <= 3'd0;
      ff46_q <= 8'h00;
      latch_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ff46_q <= ff46_d;
      latch_q <= latch_d;
      done_q <= done_d;
    end
  end
  assign dma_active_o = state_q != IDLE;
  assign dma_done_o = done_q;
endmodule

// File: tb/tb_gb_oam_dma_arbiter.sv
// tb_gb_oam_dma_arbiter: vector table for idle pass-through plus model-checked DMA runs with random CPU traffic.
module tb_gb_oam_dma_arbiter;
  localparam int LEN = 160;
  localparam int SD = 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] cpu_addr_i = 16'h0000;
  logic [7:0] cpu_data_i = 8'h00;
  logic cpu_we_i = 1'b0;
  logic [7:0] cpu_data_o, bus_data_o, bus_data_i;
  logic [15:0] bus_addr_o;
  logic bus_we_o, dma_active_o, dma_done_o;
  logic [7:0] mem [0:65535];
  logic [7:0] exp_hram [0:127];
  logic loaded = 1'b0;
  int we_cnt = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] pre(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pre(16'(i));
      loaded <= 1'b1;
    end else if (bus_we_o) mem[bus_addr_o] <= bus_data_o;
  end
  always @(posedge clk) if (bus_we_o) we_cnt <= we_cnt + 1;
  assign bus_data_i = mem[bus_addr_o];

  gb_oam_dma_arbiter #(.LEN(LEN), .START_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_data_o(cpu_data_o), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_we_o(bus_we_o), .bus_data_i(bus_data_i),
    .dma_active_o(dma_active_o), .dma_done_o(dma_done_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we);
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_we_i = we;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_pri(input logic [15:0] a);
    return a == 16'hFF46 || (a >= 16'hFF80 && a <= 16'hFFFE);
  endfunction

  function automatic logic [15:0] base_of(input logic [7:0] fv);
    return {(fv > 8'hDF) ? fv - 8'h20 : fv, 8'h00};
  endfunction

  // parks the CPU on a plain read and counts cycles until dma_done_o, -1 on timeout
  task automatic wait_done(output int done_c);
    done_c = -1;
    for (int c = 0; c < 2000 && done_c < 0; c++) begin
      drive(16'h8000, 8'h00, 1'b0);
      if (dma_done_o) done_c = c;
      step();
    end
  endtask

  task automatic oam_chk(input string nm, input logic [15:0] base);
    int err = 0;
    for (int i = 0; i < LEN; i++) if (mem[16'hFE00 + 16'(i)] !== pre(base + 16'(i))) err++;
    chk(nm, err, 0);
  endtask

  // mode 0: park on 8000, mode 1: n_hram FF90 accesses, mode 2: random CPU traffic
  task automatic run_dma(input string nm, input logic [7:0] fv, input int mode, input int n_hram);
    logic [7:0] src [0:255];
    logic [15:0] base, a;
    logic [7:0] d, c050, c8050, want;
    logic we;
    bit busy;
    int work, stalls, done_c, hcnt;
    base = base_of(fv);
    for (int i = 0; i < LEN; i++) src[i] = mem[base + 16'(i)];
    c050 = mem[16'hC050];
    c8050 = mem[16'h8050];
    drive(16'hFF46, fv, 1'b1);
    step();
    work = 0;
    stalls = 0;
    done_c = -1;
    hcnt = 0;
    for (int c = 0; c < 3000 && done_c < 0; c++) begin
      busy = c >= SD && work < 2 * LEN;
      a = 16'h8000;
      d = 8'h00;
      we = 1'b0;
      if (busy && mode == 1 && hcnt < n_hram && (c % 7) == 3) begin
        a = 16'hFF90;
        we = hcnt[0];
        d = 8'(hcnt + 1);
        hcnt++;
      end else if (busy && mode == 2) begin
        case ($urandom_range(0, 5))
          0: begin a = 16'hFF80 + 16'($urandom_range(0, 15)); d = 8'($urandom); we = 1'b1; end
          1: a = 16'hFF80 + 16'($urandom_range(0, 15));
          2: a = 16'hFF46;
          3: begin a = 16'hC050; d = 8'($urandom); we = 1'b1; end
          4: begin a = 16'h8050; d = 8'($urandom); we = 1'b1; end
          default: a = 16'h8000 + 16'($urandom_range(0, 255));
        endcase
      end
      drive(a, d, we);
      if (dma_done_o) done_c = c;
      else if (busy && is_pri(a)) begin
        stalls++;
        if (!we && a == 16'hFF46) chk({nm, "_ff46_rd"}, cpu_data_o, fv);
        else if (!we) chk({nm, "_hram_rd"}, cpu_data_o, exp_hram[a[6:0]]);
      end else if (busy) begin
`ifdef GB_DMA_BUS_CONFLICT_EN
        want = src[work / 2];
`else
        want = 8'hFF;
`endif
        if (!we) chk({nm, "_blocked_rd"}, cpu_data_o, want);
        work++;
      end
      if (we && is_pri(a)) exp_hram[a[6:0]] = d;
      step();
    end
    chk({nm, "_done_cycle"}, done_c, SD + 2 * LEN + stalls);
    if (mode == 1) chk({nm, "_stalls"}, stalls, n_hram);
    chk({nm, "_active_after"}, dma_active_o, 1'b0);
    for (int i = 0; i < LEN; i++) begin
      if (mem[16'hFE00 + 16'(i)] !== src[i]) begin
        chk({nm, "_oam"}, {16'(i), mem[16'hFE00 + 16'(i)]}, {16'(i), src[i]});
        break;
      end
    end
    total++;
    if (mode == 2) begin
      chk({nm, "_c050_kept"}, mem[16'hC050], c050);
      chk({nm, "_8050_kept"}, mem[16'h8050], c8050);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0] d;
    logic we;
    logic [7:0] rd;
    logic bwe;
  } vec_t;

  initial begin
    vec_t v [5];
    int done_c, w0;
    for (int i = 0; i < 128; i++) exp_hram[i] = pre(16'hFF80 + 16'(i));
    drive(16'hFF46, 8'h00, 1'b0);
    step();
    step();
    chk("rst_active", dma_active_o, 1'b0);
    chk("rst_done", dma_done_o, 1'b0);
    chk("rst_bus_we", bus_we_o, 1'b0);
    reset = 1'b1;
    step();
    chk("rst_ff46_rd", cpu_data_o, 8'h00);
    v[0] = '{16'hC123, 8'h5A, 1'b1, pre(16'hC123), 1'b1};
    v[1] = '{16'hC123, 8'h00, 1'b0, 8'h5A, 1'b0};
    v[2] = '{16'hFF46, 8'h00, 1'b0, 8'h00, 1'b0};
    v[3] = '{16'hFF90, 8'h33, 1'b1, pre(16'hFF90), 1'b1};
    v[4] = '{16'hFF90, 8'h00, 1'b0, 8'h33, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(v[i].a, v[i].d, v[i].we);
      chk($sformatf("idle%0d_rd", i), cpu_data_o, v[i].rd);
      chk($sformatf("idle%0d_we", i), bus_we_o, v[i].bwe);
      chk($sformatf("idle%0d_addr", i), bus_addr_o, v[i].a);
      chk($sformatf("idle%0d_active", i), dma_active_o, 1'b0);
      step();
    end
    exp_hram[16] = 8'h33;
    run_dma("basic", 8'hC0, 0, 0);
    drive(16'hFF46, 8'h00, 1'b0);
    chk("ff46_rd_c0", cpu_data_o, 8'hC0);
    run_dma("echo", 8'hE1, 0, 0);
    run_dma("hram10", 8'hC0, 1, 10);
    run_dma("rand_a", 8'hC8, 2, 0);
    run_dma("rand_b", 8'hF3, 2, 0);
    drive(16'hFF46, 8'hC0, 1'b1);
    step();
    for (int c = 0; c < 49; c++) begin
      drive(16'h8000, 8'h00, 1'b0);
      step();
    end
    chk("restart_active_mid", dma_active_o, 1'b1);
    run_dma("restart", 8'hD0, 0, 0);
    oam_chk("restart_oam_d0", 16'hD000);
    drive(16'hFF46, 8'hC0, 1'b1);
    step();
    for (int c = 0; c < SD + 2 * LEN - 1; c++) begin
      drive(16'h8000, 8'h00, 1'b0);
      step();
    end
    drive(16'hFF46, 8'hD2, 1'b1);
    chk("final_wr_we", bus_we_o, 1'b1);
    chk("final_wr_addr", bus_addr_o, 16'hFE00 + 16'(LEN - 1));
    step();
    chk("final_wr_no_done", dma_done_o, 1'b0);
    chk("final_wr_active", dma_active_o, 1'b1);
    chk("final_wr_byte", mem[16'hFE00 + 16'(LEN - 1)], pre(16'hC000 + 16'(LEN - 1)));
    wait_done(done_c);
    chk("final_restart_cycle", done_c, SD + 2 * LEN);
    oam_chk("final_restart_oam", 16'hD200);
    drive(16'hFF46, 8'hC0, 1'b1);
    step();
    for (int c = 0; c < 30; c++) begin
      drive(16'h8000, 8'h00, 1'b0);
      step();
    end
    drive(16'hFF46, 8'h00, 1'b0);
    chk("pre_rst_active", dma_active_o, 1'b1);
    reset = 1'b0;
    #1;
    w0 = we_cnt;
    chk("mid_rst_bus_we", bus_we_o, 1'b0);
    chk("mid_rst_active", dma_active_o, 1'b0);
    chk("mid_rst_done", dma_done_o, 1'b0);
    chk("mid_rst_ff46", cpu_data_o, 8'h00);
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(16'h8000, 8'h00, 1'b0);
      step();
    end
    chk("post_rst_writes", we_cnt - w0, 0);
    chk("post_rst_active", dma_active_o, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
